// File: rtl/core_acc.sv
// ============================================================================
// core_acc : signed saturating partial-sum accumulator feeding the quantizer
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ODATA_WIDTH
`define ODATA_WIDTH 24
`endif
`ifndef CDATA_ACCU_NUM_WIDTH
`define CDATA_ACCU_NUM_WIDTH 10
`endif

module core_acc #(
    parameter int IDATA_WIDTH          = 16,
    parameter int ODATA_WIDTH          = `ODATA_WIDTH,
    parameter int CDATA_ACCU_NUM_WIDTH = `CDATA_ACCU_NUM_WIDTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [CDATA_ACCU_NUM_WIDTH-1:0] cfg_acc_num,
    input  logic [IDATA_WIDTH-1:0]          idata,
    input  logic                            idata_valid,
    input  logic                            acc_clear,
    output logic [ODATA_WIDTH-1:0]          odata,
    output logic                            odata_valid,
    output logic                            odata_ovf,
    output logic                            acc_busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [CDATA_ACCU_NUM_WIDTH-1:0] CNT_ONE  = {{(CDATA_ACCU_NUM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CDATA_ACCU_NUM_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [ODATA_WIDTH-1:0]          SAT_MAX  = {1'b0, {(ODATA_WIDTH-1){1'b1}}};
    localparam logic [ODATA_WIDTH-1:0]          SAT_MIN  = {1'b1, {(ODATA_WIDTH-1){1'b0}}};

    logic [0:0]                      state;
    logic [ODATA_WIDTH-1:0]          acc;
    logic [CDATA_ACCU_NUM_WIDTH-1:0] cnt;
    logic [CDATA_ACCU_NUM_WIDTH-1:0] n_lat;
    logic                            ovf_grp;

    logic [CDATA_ACCU_NUM_WIDTH-1:0] n_sel;
    logic [CDATA_ACCU_NUM_WIDTH-1:0] n_eff;
    logic [ODATA_WIDTH-1:0]          acc_base;
    logic [ODATA_WIDTH:0]            sum_wide;
    logic [ODATA_WIDTH-1:0]          sum_sat;
    logic                            beat_clamped;
    logic                            is_final;

    always_comb begin
        // The first beat of a group uses the live config; later beats the latched one.
        n_sel    = (state == S_IDLE) ? cfg_acc_num : n_lat;
        n_eff    = (n_sel == CNT_ZERO) ? CNT_ONE : n_sel;
        acc_base = (state == S_IDLE) ? '0 : acc;
        sum_wide = {acc_base[ODATA_WIDTH-1], acc_base}
                 + {{(ODATA_WIDTH+1-IDATA_WIDTH){idata[IDATA_WIDTH-1]}}, idata};
        beat_clamped = sum_wide[ODATA_WIDTH] != sum_wide[ODATA_WIDTH-1];
        if (beat_clamped) begin
            sum_sat = sum_wide[ODATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_sat = sum_wide[ODATA_WIDTH-1:0];
        end
        is_final = (cnt == (n_eff - CNT_ONE));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            acc         <= '0;
            cnt         <= '0;
            n_lat       <= '0;
            ovf_grp     <= 1'b0;
            odata       <= '0;
            odata_valid <= 1'b0;
            odata_ovf   <= 1'b0;
            acc_busy    <= 1'b0;
        end else begin
            odata_valid <= 1'b0;
            if (acc_clear) begin
                // Clear takes priority over any beat presented in the same cycle.
                state    <= S_IDLE;
                acc      <= '0;
                cnt      <= '0;
                ovf_grp  <= 1'b0;
                acc_busy <= 1'b0;
            end else if (idata_valid) begin
                if (state == S_IDLE) begin
                    n_lat <= cfg_acc_num;
                end
                if (is_final) begin
                    odata       <= sum_sat;
                    odata_ovf   <= ovf_grp | beat_clamped;
                    odata_valid <= 1'b1;
                    state       <= S_IDLE;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf_grp     <= 1'b0;
                    acc_busy    <= 1'b0;
                end else begin
                    state    <= S_ACCUM;
                    acc      <= sum_sat;
                    cnt      <= cnt + CNT_ONE;
                    ovf_grp  <= ovf_grp | beat_clamped;
                    acc_busy <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_acc.sv
// ============================================================================
// tb_core_acc : directed-vector bench for core_acc with an integer group model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_core_acc;

    localparam int IW = 16;
    localparam int OW = 24;
    localparam int CW = 10;
    localparam longint OMAX = (64'sd1 <<< (OW-1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OW-1));

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [CW-1:0] cfg_acc_num = '0;
    logic [IW-1:0] idata = '0;
    logic          idata_valid = 1'b0;
    logic          acc_clear = 1'b0;
    logic [OW-1:0] odata;
    logic          odata_valid;
    logic          odata_ovf;
    logic          acc_busy;

    core_acc #(.IDATA_WIDTH(IW), .ODATA_WIDTH(OW), .CDATA_ACCU_NUM_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn), .cfg_acc_num(cfg_acc_num), .idata(idata),
        .idata_valid(idata_valid), .acc_clear(acc_clear), .odata(odata),
        .odata_valid(odata_valid), .odata_ovf(odata_ovf), .acc_busy(acc_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // Group model: integer running sum clamped after every add.
    int            m_cnt = 0;
    int            m_n = 1;
    longint        m_sum = 0;
    bit            m_ovf = 1'b0;
    bit            exp_valid = 1'b0;
    logic [OW-1:0] exp_odata = '0;
    bit            exp_ovf = 1'b0;
    bit            exp_busy = 1'b0;

    logic [OW-1:0] got_q[$];
    bit            got_ovf_q[$];

    task automatic model_step();
        longint s;
        if (!rstn) begin
            m_cnt = 0; m_sum = 0; m_ovf = 1'b0;
            exp_valid = 1'b0; exp_odata = '0; exp_ovf = 1'b0; exp_busy = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (acc_clear) begin
                m_cnt = 0; m_sum = 0; m_ovf = 1'b0;
            end else if (idata_valid) begin
                if (m_cnt == 0) m_n = (cfg_acc_num == 0) ? 1 : int'(cfg_acc_num);
                s = m_sum + longint'($signed(idata));
                if (s > OMAX) begin s = OMAX; m_ovf = 1'b1; end
                if (s < OMIN) begin s = OMIN; m_ovf = 1'b1; end
                m_sum = s;
                m_cnt++;
                if (m_cnt == m_n) begin
                    exp_odata = s[OW-1:0];
                    exp_ovf   = m_ovf;
                    exp_valid = 1'b1;
                    m_cnt = 0; m_sum = 0; m_ovf = 1'b0;
                end
            end
            exp_busy = (m_cnt != 0);
        end
    endtask

    task automatic check(string name, longint act, longint want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("odata_valid", longint'(odata_valid), longint'(exp_valid));
                check("acc_busy", longint'(acc_busy), longint'(exp_busy));
                check("odata", longint'(odata), longint'(exp_odata));
                check("odata_ovf", longint'(odata_ovf), longint'(exp_ovf));
                if (odata_valid === 1'b1) begin
                    got_q.push_back(odata);
                    got_ovf_q.push_back(odata_ovf);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        checking = 1'b1;
        #1;
    endtask

    task automatic beat(int d, int cfg = -1, bit clr = 1'b0);
        if (cfg >= 0) cfg_acc_num = CW'(cfg);
        idata       = d[IW-1:0];
        idata_valid = 1'b1;
        acc_clear   = clr;
        step();
        idata_valid = 1'b0;
        acc_clear   = 1'b0;
    endtask

    task automatic idle(int n);
        idata_valid = 1'b0;
        acc_clear   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Hand-computed expectation for the next captured output pulse.
    task automatic expect_out(string name, logic [OW-1:0] v, bit ovf);
        vectors++;
        if (got_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got no pulse want %0h", name, v);
        end else begin
            logic [OW-1:0] g;
            bit go;
            g  = got_q.pop_front();
            go = got_ovf_q.pop_front();
            if (g !== v || go !== ovf) begin
                miscompares++;
                $display("FAIL %s: got %0h/ovf%0d want %0h/ovf%0d", name, g, go, v, ovf);
            end
        end
    endtask

    task automatic expect_none(string name);
        check(name, longint'(got_q.size()), 0);
        got_q.delete();
        got_ovf_q.delete();
    endtask

    initial begin
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(1);

        // Basic sum
        cfg_acc_num = 10'd4;
        for (int i = 1; i <= 4; i++) beat(i);
        idle(2);
        expect_out("basic_sum", 24'd10, 1'b0);

        // Signed with gaps
        beat(-5, 3); idle(2);
        beat(7);     idle(2);
        expect_none("gap_no_early_pulse");
        beat(-10);   idle(2);
        expect_out("signed_gaps", 24'hFFFFF8, 1'b0);

        // Saturation both directions, then sticky flag cleared
        for (int i = 0; i < 300; i++) beat(32767, 300);
        idle(1);
        expect_out("sat_pos", 24'h7FFFFF, 1'b1);
        for (int i = 0; i < 300; i++) beat(-32768);
        idle(1);
        expect_out("sat_neg", 24'h800000, 1'b1);
        beat(5, 2); beat(5); idle(1);
        expect_out("sticky_cleared", 24'd10, 1'b0);

        // Back-to-back groups; config changes mid-group are ignored
        beat(1, 2); beat(2); beat(3); beat(4, 3); beat(5, 2); beat(6, 3);
        beat(1); beat(1); beat(1);
        idle(2);
        expect_out("b2b_g1", 24'd3, 1'b0);
        expect_out("b2b_g2", 24'd7, 1'b0);
        expect_out("b2b_g3", 24'd11, 1'b0);
        expect_out("cfg_new_n3", 24'd3, 1'b0);

        // Pass-through with N=0 and N=1
        beat(9, 0); beat(-1, 1); idle(2);
        expect_out("pass_n0", 24'd9, 1'b0);
        expect_out("pass_n1", 24'hFFFFFF, 1'b0);

        // Clear wins over a simultaneous beat
        beat(1, 4); beat(2); beat(100, 4, 1'b1); idle(2);
        expect_none("clear_no_output");
        for (int i = 0; i < 4; i++) beat(1);
        idle(1);
        expect_out("after_clear", 24'd4, 1'b0);

        // Reset mid-group
        beat(7, 10); idle(1);
        beat(1, 4); beat(2);
        rstn = 1'b0; idle(1);
        rstn = 1'b1; idle(3);
        expect_none("reset_no_stale_pulse");
        for (int i = 0; i < 4; i++) beat(1);
        idle(1);
        expect_out("after_reset", 24'd4, 1'b0);
        expect_none("no_extra_pulses");

        checking = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_acc.md
# core_acc

Signed partial-sum accumulator that sits directly upstream of the core quantizer. It sums a configurable number of `IDATA_WIDTH` partial products from the MAC array into one `ODATA_WIDTH` result, saturating at each add. It emits one valid pulse per completed group, and that pulse drives the quantizer's `idata`/`idata_valid` directly. There is no backpressure: the quantizer always accepts.

## Interface
- `IDATA_WIDTH`, default 16: width of the signed partial-sum input.
- `ODATA_WIDTH`, default `` `ODATA_WIDTH `` (24): width of the signed accumulated output, which is the quantizer input width.
- `CDATA_ACCU_NUM_WIDTH`, default `` `CDATA_ACCU_NUM_WIDTH `` (10): width of the accumulation-count config.

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rstn`  in  1  Reset: synchronous, active-low.
- `cfg_acc_num`  in  `CDATA_ACCU_NUM_WIDTH`  Beats per group (N). A value of 0 is treated as 1.
- `idata`  in  `IDATA_WIDTH`  Signed partial sum.
- `idata_valid`  in  1  `idata` is valid this cycle.
- `acc_clear`  in  1  Synchronous abort of the group in progress.
- `odata`  out  `ODATA_WIDTH`  Signed accumulated result.
- `odata_valid`  out  1  One-cycle pulse; `odata` is valid.
- `odata_ovf`  out  1  Qualified by `odata_valid`: saturation occurred somewhere in this group.
- `acc_busy`  out  1  High while a group is partially accumulated.

## Operation
- **States:**
  - IDLE: no beats held.
  - ACCUM: 1 to N-1 beats held.
- **Beat counter `cnt`:**
  - Counts accepted beats and is 0 in IDLE.
  - `cfg_acc_num` is latched into `n_lat` on the first beat of a group (IDLE with `idata_valid`).
  - Changes to `cfg_acc_num` during ACCUM are ignored until the next group.
- **Add rule:**
  - `sum = sext(acc, ODATA_WIDTH+1) + sext(idata, ODATA_WIDTH+1)`.
  - The sum is clamped to [-2^(ODATA_WIDTH-1), 2^(ODATA_WIDTH-1)-1].
  - If clamping happens, set sticky `ovf_grp`.
  - The first beat of a group adds to 0, not to the old `acc`.
- **Final beat:** the beat where `cnt == n_eff-1`, with `n_eff = max(n_lat, 1)`. On that beat:
  - Register `odata <= clamped sum`.
  - Register `odata_ovf <= ovf_grp | this_beat_clamped`.
  - Assert `odata_valid` for the next cycle.
  - Zero `acc`, `cnt` and `ovf_grp`, and go to IDLE.
- **Transitions:**
  - IDLE to ACCUM: on a beat when `n_eff > 1`.
  - IDLE stays IDLE: on a beat when `n_eff == 1`, which is the pass-through case producing one output per beat.
  - ACCUM to IDLE: on the final beat.
- **Idle cycles:** with `idata_valid` low, the state, `acc` and `cnt` hold. Gaps inside a group are allowed.
- **`acc_clear`:**
  - Zeroes `acc`, `cnt` and `ovf_grp`, goes to IDLE, and produces no output.
  - If `idata_valid` is high in the same cycle, clear wins and the beat is discarded, even if it would have been the final beat.
- **`acc_busy`:** equals (state == ACCUM), registered.
- **`odata` / `odata_ovf` hold:** both hold their last values between pulses.
- **Reset (`rstn` low at a clock edge):**
  - `odata`, `odata_valid`, `odata_ovf` and `acc_busy` go to 0.
  - `acc` and `cnt` go to 0, and the state goes to IDLE.
  - This applies mid-group too; the partial group is lost with no output.

## Timing
- **Latency:** the final beat at edge t gives `odata_valid` high in the cycle after t, for exactly one cycle.
- **Throughput:**
  - One beat per cycle.
  - Back-to-back groups need no bubble: the beat after a final beat starts a new group.
  - With N=1, `odata_valid` can be high every cycle.
- **Critical path:** one (`ODATA_WIDTH`+1)-bit add, then the clamp, then the register. No multiplier.
- **First cycle after reset release:** input is accepted normally.

## Test plan
- **Basic sum:** N=4, beats 1,2,3,4 on consecutive cycles → one `odata_valid` pulse, 1 cycle after beat 4, with `odata`=10 and `odata_ovf`=0. `acc_busy` is high for the 3 cycles after beats 1–3.
- **Signed with gaps:** N=3, beats -5, 7, -10 with 2 idle cycles between each → `odata`=0xFFFFF8 (-8). No pulse before the third beat.
- **Saturation:** N=300, every beat 32767 → `odata`=0x7FFFFF and `odata_ovf`=1. Repeat with -32768 → `odata`=0x800000 and `odata_ovf`=1. Next group N=2, beats 5,5 → `odata`=10 and `odata_ovf`=0, showing the sticky flag cleared.
- **Back-to-back and config latch:** N=2, stream 1..6 continuously; change `cfg_acc_num` to 3 after beat 3. Expected outputs:
  - 3 (beats 1,2).
  - 7 (beats 3,4, N still 2 because the group was latched at N=2).
  - 11 (beats 5,6, then N=3 applies from the next group).
- **Pass-through:** N=0 and N=1, beats 9, -1 → two consecutive pulses with `odata`=9 then 0xFFFFFF. `acc_busy` stays 0.
- **Clear and reset:**
  - N=4, beats 1,2, then `acc_clear` with a simultaneous beat 100 → no output and `acc_busy`=0. Then beats 1,1,1,1 → `odata`=4.
  - Repeat with `rstn` low mid-group → all outputs 0 the cycle after the reset edge, and no stale pulse afterwards.
